// File: rtl/conv_seq_pkg.sv
// ============================================================================
// Module  : conv_seq_pkg
// Brief   : Shared state encoding and sizing helper for the conv layer sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv_seq_state_t;

  // Wide enough to hold a full-frame count (0..W*W inclusive).
  function automatic int pix_cnt_width(input int image_width);
    return $clog2(image_width * image_width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_seq_pacer.sv
// ============================================================================
// Module  : conv_seq_pacer
// Brief   : Down-counter enforcing a minimum spacing between issued pixels.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_seq_pacer
  import conv_seq_pkg::*;
#(
  parameter int CYCLES_PER_PIXEL = 2
) (
  input  logic clk,
  input  logic res_n,
  input  logic i_load,
  output logic o_pace_ok
);

  localparam int c_PW = (CYCLES_PER_PIXEL > 1) ? $clog2(CYCLES_PER_PIXEL) : 1;
  localparam logic [c_PW-1:0] c_RELOAD = c_PW'(CYCLES_PER_PIXEL - 1);

  logic [c_PW-1:0] r_pace_cnt;

  always_ff @(posedge clk) begin
    if (res_n) begin
      r_pace_cnt <= '0;
    end else if (i_load) begin
      r_pace_cnt <= c_RELOAD;
    end else if (r_pace_cnt != '0) begin
      r_pace_cnt <= r_pace_cnt - c_PW'(1);
    end
  end

  assign o_pace_ok = (r_pace_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/conv_layer_sequencer.sv
// ============================================================================
// Module  : conv_layer_sequencer
// Brief   : Frame controller pacing a pixel stream into a conv+pool layer.
//           Optional drain watchdog enabled by defining CONV_SEQ_WATCHDOG_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int BIT_SIZE         = 32,
  parameter int IMAGE_WIDTH      = 4,
  parameter int CYCLES_PER_PIXEL = 2,
  parameter int DRAIN_TIMEOUT    = 256
) (
  input  logic                                 clk,
  input  logic                                 res_n,
  input  logic                                 start,
  input  logic                                 src_valid,
  input  logic [BIT_SIZE-1:0]                  src_data,
  output logic                                 src_ready,
  input  logic                                 layer_out_ready,
  input  logic                                 layer_pooling_done,
  output logic                                 layer_in_valid,
  output logic [BIT_SIZE-1:0]                  layer_in_data,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic [pix_cnt_width(IMAGE_WIDTH)-1:0] pix_count,
  output logic                                 timeout_err
);

  localparam int c_PCW = pix_cnt_width(IMAGE_WIDTH);
  localparam logic [c_PCW-1:0] c_LAST = c_PCW'(IMAGE_WIDTH * IMAGE_WIDTH - 1);

  conv_seq_state_t     r_state;
  logic [c_PCW-1:0]    r_pix_count;
  logic                r_layer_in_valid;
  logic [BIT_SIZE-1:0] r_layer_in_data;
  logic                r_frame_done;
  logic                r_done_seen;
  logic                r_pool_d;

  logic w_pace_ok;
  logic w_accept;
  logic w_pool_rise;

`ifdef CONV_SEQ_WATCHDOG_EN
  localparam int c_DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [c_DW-1:0] c_DT_LAST = c_DW'(DRAIN_TIMEOUT - 1);
  logic [c_DW-1:0] r_drain_cnt;
  logic            r_timeout_err;
`endif

  conv_seq_pacer #(
    .CYCLES_PER_PIXEL (CYCLES_PER_PIXEL)
  ) u_pacer (
    .clk       (clk),
    .res_n     (res_n),
    .i_load    (w_accept),
    .o_pace_ok (w_pace_ok)
  );

  assign src_ready   = (r_state == FEED) & w_pace_ok & layer_out_ready;
  assign w_accept    = src_valid & src_ready;
  // Only an edge counts, so a level left high by a previous frame is ignored.
  assign w_pool_rise = layer_pooling_done & ~r_pool_d;

  always_ff @(posedge clk) begin
    if (res_n) begin
      r_state          <= IDLE;
      r_pix_count      <= '0;
      r_layer_in_valid <= 1'b0;
      r_layer_in_data  <= '0;
      r_frame_done     <= 1'b0;
      r_done_seen      <= 1'b0;
      r_pool_d         <= 1'b0;
`ifdef CONV_SEQ_WATCHDOG_EN
      r_drain_cnt      <= '0;
      r_timeout_err    <= 1'b0;
`endif
    end else begin
      r_pool_d         <= layer_pooling_done;
      r_layer_in_valid <= w_accept;
      r_frame_done     <= 1'b0;
      if (w_accept) begin
        r_layer_in_data <= src_data;
        r_pix_count     <= r_pix_count + c_PCW'(1);
      end
      if (w_pool_rise && (r_state == FEED || r_state == DRAIN)) begin
        r_done_seen <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= FEED;
            r_pix_count <= '0;
            r_done_seen <= 1'b0;
`ifdef CONV_SEQ_WATCHDOG_EN
            r_drain_cnt   <= '0;
            r_timeout_err <= 1'b0;
`endif
          end
        end
        FEED: begin
          if (w_accept && r_pix_count == c_LAST) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_done_seen) begin
            r_state      <= DONE;
            r_frame_done <= 1'b1;
          end
`ifdef CONV_SEQ_WATCHDOG_EN
          else if (r_drain_cnt == c_DT_LAST) begin
            r_state       <= DONE;
            r_frame_done  <= 1'b1;
            r_timeout_err <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + c_DW'(1);
          end
`endif
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign layer_in_valid = r_layer_in_valid;
  assign layer_in_data  = r_layer_in_data;
  assign frame_done     = r_frame_done;
  assign pix_count      = r_pix_count;
  assign busy           = (r_state != IDLE);

`ifdef CONV_SEQ_WATCHDOG_EN
  assign timeout_err = r_timeout_err;
`else
  // No watchdog: DRAIN waits indefinitely and the flag never sets.
  assign timeout_err = (DRAIN_TIMEOUT < 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
// ============================================================================
// Module  : tb_conv_layer_sequencer
// Brief   : Directed self-checking bench for conv_layer_sequencer (CPP=2 and CPP=1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_layer_sequencer;

  logic        clk;
  logic        res_n;
  logic        start;
  logic        start1;
  logic        src_valid;
  logic [31:0] src_data;
  logic        layer_out_ready;
  logic        pd;

  logic        src_ready, liv, busy, fd, te;
  logic [31:0] lid;
  logic [4:0]  pc;
  logic        s1_ready, v1, busy1, fd1, te1;
  logic [31:0] d1;
  logic [4:0]  pc1;

  int errors = 0;
  int checks = 0;
  int k, rx, last, cnt;

  localparam logic [31:0] c_B1 = 32'hA000_0000;
  localparam logic [31:0] c_B2 = 32'h5500_0100;

  conv_layer_sequencer #(
    .BIT_SIZE(32), .IMAGE_WIDTH(4), .CYCLES_PER_PIXEL(2), .DRAIN_TIMEOUT(8)
  ) u_dut (
    .clk(clk), .res_n(res_n), .start(start), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .layer_out_ready(layer_out_ready), .layer_pooling_done(pd),
    .layer_in_valid(liv), .layer_in_data(lid), .busy(busy), .frame_done(fd),
    .pix_count(pc), .timeout_err(te)
  );

  conv_layer_sequencer #(
    .BIT_SIZE(32), .IMAGE_WIDTH(4), .CYCLES_PER_PIXEL(1), .DRAIN_TIMEOUT(8)
  ) u_dut1 (
    .clk(clk), .res_n(res_n), .start(start1), .src_valid(src_valid), .src_data(src_data),
    .src_ready(s1_ready), .layer_out_ready(layer_out_ready), .layer_pooling_done(pd),
    .layer_in_valid(v1), .layer_in_data(d1), .busy(busy1), .frame_done(fd1),
    .pix_count(pc1), .timeout_err(te1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic feed_to(input int n);
    int c;
    c = 0;
    while (int'(pc) < n && c < 200) begin
      tick();
      c++;
    end
    chk("feed_to_count", 64'(pc), 64'(n));
  endtask

  initial begin
    res_n = 1'b1; start = 1'b0; start1 = 1'b0; src_valid = 1'b0;
    src_data = '0; layer_out_ready = 1'b0; pd = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_busy", 64'(busy), 0);
    chk("rst_frame_done", 64'(fd), 0);
    chk("rst_pix_count", 64'(pc), 0);
    chk("rst_in_valid", 64'(liv), 0);
    chk("rst_in_data", 64'(lid), 0);
    chk("rst_timeout", 64'(te), 0);
    chk("rst_busy1", 64'(busy1), 0);
    res_n = 1'b0;
    tick();
    chk("idle_src_ready", 64'(src_ready), 0);

    // Test 1: CPP=2, full frame, pixels two cycles apart
    src_valid = 1'b1; layer_out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_busy", 64'(busy), 1);
    k = 0; rx = 0; last = -1; src_data = c_B1;
    for (int cyc = 0; cyc < 80 && k < 16; cyc++) begin
      if (src_ready) begin
        if (last >= 0) chk("t1_pace_gap", 64'(cyc - last), 2);
        last = cyc;
        k++;
      end
      tick();
      if (liv) begin
        chk("t1_data", 64'(lid), 64'(c_B1 + 32'(rx)));
        rx++;
      end
      src_data = c_B1 + 32'(k);
    end
    chk("t1_accepts", 64'(k), 16);
    chk("t1_issued", 64'(rx), 16);
    chk("t1_pix_count", 64'(pc), 16);
    src_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_drain_ready", 64'(src_ready), 0);
      chk("t1_drain_fd", 64'(fd), 0);
    end
    pd = 1'b1; tick(); pd = 1'b0;
    chk("t1_fd_early", 64'(fd), 0);
    tick();
    chk("t1_frame_done", 64'(fd), 1);
    chk("t1_done_busy", 64'(busy), 1);
    tick();
    chk("t1_fd_pulse", 64'(fd), 0);
    chk("t1_idle", 64'(busy), 0);
    chk("t1_pc_hold", 64'(pc), 16);

    // Test 2: CPP=1, back-to-back accepts with 1-cycle latency
    src_valid = 1'b1; src_data = c_B2;
    start1 = 1'b1; tick(); start1 = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && k < 16; c++) begin
      chk("t2_ready", 64'(s1_ready), 1);
      k++;
      tick();
      chk("t2_valid", 64'(v1), 1);
      chk("t2_data", 64'(d1), 64'(c_B2 + 32'(k - 1)));
      src_data = c_B2 + 32'(k);
    end
    src_valid = 1'b0;
    tick();
    chk("t2_valid_end", 64'(v1), 0);
    chk("t2_pix_count", 64'(pc1), 16);
    pd = 1'b1; tick(); pd = 1'b0; tick();
    chk("t2_frame_done", 64'(fd1), 1);
    tick();
    chk("t2_idle", 64'(busy1), 0);
    chk("t2_dut0_idle", 64'(busy), 0);

    // Tests 3+4: stall mid-frame; pooling_done level held from before the frame
    pd = 1'b1; tick();
    src_valid = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    feed_to(6);
    layer_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_ready", 64'(src_ready), 0);
      start = (i == 2);
      tick();
      chk("t3_pc_frozen", 64'(pc), 6);
    end
    start = 1'b0;
    chk("t3_stall_valid", 64'(liv), 0);
    chk("t3_no_error", 64'(te), 0);
    layer_out_ready = 1'b1;
    feed_to(16);
    src_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold_busy", 64'(busy), 1);
      chk("t4_hold_fd", 64'(fd), 0);
    end
    pd = 1'b0; tick();
    chk("t4_fall_fd", 64'(fd), 0);
    pd = 1'b1; tick();
    chk("t4_rise_fd", 64'(fd), 0);
    tick();
    chk("t4_frame_done", 64'(fd), 1);
    pd = 1'b0; tick();
    chk("t4_idle", 64'(busy), 0);

    // Test 5: reset at pixel 7 abandons the frame
    src_valid = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    feed_to(7);
    res_n = 1'b1; tick(); res_n = 1'b0;
    chk("t5_busy", 64'(busy), 0);
    chk("t5_pix_count", 64'(pc), 0);
    chk("t5_in_valid", 64'(liv), 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (fd) cnt++;
      tick();
    end
    chk("t5_no_frame_done", 64'(cnt), 0);
    start = 1'b1; tick(); start = 1'b0;
    feed_to(16);
    src_valid = 1'b0;
    pd = 1'b1; tick(); pd = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (fd) cnt++;
    end
    chk("t5_one_pulse", 64'(cnt), 1);
    chk("t5_end_idle", 64'(busy), 0);

`ifdef CONV_SEQ_WATCHDOG_EN
    // Test 6: watchdog fires after 8 DRAIN cycles with no pooling_done
    src_valid = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    feed_to(16);
    src_valid = 1'b0;
    cnt = 0;
    while (!fd && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("t6_drain_cycles", 64'(cnt), 8);
    chk("t6_timeout", 64'(te), 1);
    tick(); tick();
    chk("t6_idle", 64'(busy), 0);
    chk("t6_sticky", 64'(te), 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t6_cleared", 64'(te), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
